// File: rtl/score_collect_pkg.sv
// ---------------------------------------------------------------------------
// score_collect_pkg
//
// Purpose: shared constants, the collector FSM state type and byte-slice
//          helpers for the classifier result path (score_collect and its
//          argmax_seq sub-module).
//
// Contents:
//   NUM_CLASS  scores per frame
//   SCORE_W    bits per two's-complement score
//   IDX_W      class index width, 2**IDX_W must cover NUM_CLASS
//   FRAME_W    width of the packed result word
//   LAST_IDX   index of the final class in a frame
//   state_t    IDLE / COLLECT / ARGMAX / EMIT
//   get_byte   read one signed score out of a packed frame
//   put_byte   replace one score inside a packed frame
// ---------------------------------------------------------------------------
package score_collect_pkg;

    localparam int NUM_CLASS = 10;
    localparam int SCORE_W   = 8;
    localparam int IDX_W     = 4;
    localparam int FRAME_W   = NUM_CLASS * SCORE_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ARGMAX,
        EMIT
    } state_t;

    typedef logic signed [SCORE_W-1:0] score_t;

    // Class 0 lives in the low byte, class N in bits [N*SCORE_W +: SCORE_W].
    function automatic score_t get_byte(input logic [FRAME_W-1:0] frame,
                                        input logic [IDX_W-1:0]   idx);
        return frame[int'(idx)*SCORE_W +: SCORE_W];
    endfunction

    function automatic logic [FRAME_W-1:0] put_byte(input logic [FRAME_W-1:0] frame,
                                                    input logic [IDX_W-1:0]   idx,
                                                    input logic [SCORE_W-1:0] value);
        logic [FRAME_W-1:0] result;
        result = frame;
        result[int'(idx)*SCORE_W +: SCORE_W] = value;
        return result;
    endfunction

endpackage

// File: rtl/score_collect_argmax_seq.sv
// ---------------------------------------------------------------------------
// argmax_seq
//
// Purpose: sequential signed argmax over a packed frame of NUM_CLASS scores.
//          One comparison per clock against the running maximum. Strict
//          greater-than, so ties keep the lower class index.
//
// Timing: the clock edge that sees start loads class 0 as the running max.
//         The following NUM_CLASS-1 edges each compare one more class. The
//         edge that compares the final class publishes best_idx/best_max and
//         raises done for the next cycle. Total: NUM_CLASS edges from start.
//         The scores input must stay stable while the search runs.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   start       one-cycle pulse that begins a search
//   scores      packed frame, class 0 in the low byte
//   done        one-cycle strobe, published results are valid
//   best_idx    winning class index, held until the next search completes
//   best_max    winning score, held like best_idx
// ---------------------------------------------------------------------------
module argmax_seq
    import score_collect_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] scores,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output score_t             best_max
);

    logic             busy;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] run_idx;
    score_t           run_max;
    score_t           cand;
    logic             cand_wins;

    assign cand      = get_byte(scores, cnt);
    assign cand_wins = (cand > run_max);

    // Running search. The published results only change on the final
    // comparison, so downstream logic never sees a half-finished winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            run_idx  <= '0;
            run_max  <= '0;
            done     <= 1'b0;
            best_idx <= '0;
            best_max <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                cnt     <= IDX_W'(1);
                run_idx <= '0;
                run_max <= get_byte(scores, '0);
            end else if (busy) begin
                if (cand_wins) begin
                    run_idx <= cnt;
                    run_max <= cand;
                end
                cnt <= cnt + IDX_W'(1);
                if (cnt == LAST_IDX) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    best_idx <= cand_wins ? cnt  : run_idx;
                    best_max <= cand_wins ? cand : run_max;
                end
            end
        end
    end

endmodule

// File: rtl/score_collect.sv
// ---------------------------------------------------------------------------
// score_collect
//
// Purpose: collects the NUM_CLASS class scores of the final fully-connected
//          layer over a valid/ready stream, packs them into one result word
//          and finds the winning class with argmax_seq. The packed word is
//          shown for exactly one cycle and is zero otherwise, because the
//          UART sender treats any non-zero word as new data.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   score_vld     score beat valid
//   score_data    signed score for the current class
//   score_last    marks the final beat of a frame
//   score_rdy     block can accept a beat (IDLE/COLLECT only)
//   model_output  packed scores during EMIT, zero otherwise
//   out_vld       one-cycle strobe coincident with model_output
//   pred_class    argmax index, held until the next frame completes
//   frame_err     one-cycle framing-error strobe
// ---------------------------------------------------------------------------
module score_collect
    import score_collect_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               score_vld,
    input  logic [SCORE_W-1:0] score_data,
    input  logic               score_last,
    output logic               score_rdy,
    output logic [FRAME_W-1:0] model_output,
    output logic               out_vld,
    output logic [IDX_W-1:0]   pred_class,
    output logic               frame_err
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [FRAME_W-1:0] score_buf;
    logic               frame_err_q;

    logic               accept;
    logic               idx_at_last;
    logic               argmax_start;
    logic               argmax_done;
    logic [IDX_W-1:0]   best_idx;
    score_t             win_score;
    logic               emit_score_ok;

    // score_rdy is gated by rst itself so it reads 0 for the whole time
    // reset is held, not just after the first clock edge.
    assign score_rdy    = ((state == IDLE) || (state == COLLECT)) && !rst;
    assign accept       = score_vld && score_rdy;
    assign idx_at_last  = (idx == LAST_IDX);

    // idx doubles as the ARGMAX cycle counter; it restarts at 0 on entry,
    // and the search is kicked off in that first ARGMAX cycle, once the
    // final score has already landed in the buffer.
    assign argmax_start = (state == ARGMAX) && (idx == '0);

    assign pred_class   = best_idx;
    assign frame_err    = frame_err_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and EMIT outputs. An early last beat sends the FSM back
    // to IDLE; a beat in the final slot always completes the frame, with
    // or without score_last.
    always_comb begin
        state_nxt    = state;
        out_vld      = 1'b0;
        model_output = '0;
        unique case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (idx_at_last) begin
                        state_nxt = ARGMAX;
                    end else if (score_last) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            ARGMAX: begin
                if (idx_at_last) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_vld      = 1'b1;
                model_output = score_buf;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Packing buffer, beat/cycle index and the framing-error strobe.
    // The buffer is wiped when a frame is abandoned and after EMIT, so a
    // fresh frame never inherits bytes from an older one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            score_buf   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (idx_at_last) begin
                            score_buf   <= put_byte(score_buf, idx, score_data);
                            idx         <= '0;
                            frame_err_q <= !score_last;
                        end else if (score_last) begin
                            score_buf   <= '0;
                            idx         <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            score_buf   <= put_byte(score_buf, idx, score_data);
                            idx         <= idx + IDX_W'(1);
                        end
                    end
                end
                ARGMAX: begin
                    idx <= idx_at_last ? '0 : idx + IDX_W'(1);
                end
                EMIT: begin
                    score_buf <= '0;
                    idx       <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    argmax_seq u_argmax (
        .clk      (clk),
        .rst      (rst),
        .start    (argmax_start),
        .scores   (score_buf),
        .done     (argmax_done),
        .best_idx (best_idx),
        .best_max (win_score)
    );

    // The search finishes exactly as EMIT opens, and the winning score it
    // reports must be the byte the winning index points at.
    assign emit_score_ok = (win_score == get_byte(score_buf, best_idx));

    a_done_in_emit: assert property (@(posedge clk) disable iff (rst)
        argmax_done == (state == EMIT));

    a_winner_consistent: assert property (@(posedge clk) disable iff (rst)
        (state == EMIT) |-> emit_score_ok);

endmodule

// File: tb/tb_score_collect.sv
// ---------------------------------------------------------------------------
// tb_score_collect
//
// Randomised and directed frames for score_collect. Whenever a frame's last
// beat is about to be accepted, the expected result (packed word, winning
// class, cycle of the out_vld pulse) or the expected framing-error pulse is
// queued from a plain-arithmetic reference model. A separate monitor pops
// those entries when the DUT presents out_vld or frame_err.
//
// Cycle counting: cyc steps on every rising edge. If the last beat is taken
// at edge T, ARGMAX fills the next 10 cycles and EMIT is the 11th cycle, the
// one opened by edge T+NUM_CLASS. frame_err appears in the cycle opened by
// edge T.
// ---------------------------------------------------------------------------
module tb_score_collect;
    import score_collect_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               score_vld = 1'b0;
    logic [SCORE_W-1:0] score_data = '0;
    logic               score_last = 1'b0;
    logic               score_rdy;
    logic [FRAME_W-1:0] model_output;
    logic               out_vld;
    logic [IDX_W-1:0]   pred_class;
    logic               frame_err;

    typedef logic [SCORE_W-1:0] frame_t [NUM_CLASS];

    typedef struct {
        logic [FRAME_W-1:0] word;
        logic [IDX_W-1:0]   cls;
        int                 at;
    } exp_t;

    exp_t             expQ[$];
    int               errQ[$];
    logic [IDX_W-1:0] heldCls = '0;
    int               cyc = 0;
    int               checksTotal = 0;
    int               checksPassed = 0;

    score_collect dut (
        .clk          (clk),
        .rst          (rst),
        .score_vld    (score_vld),
        .score_data   (score_data),
        .score_last   (score_last),
        .score_rdy    (score_rdy),
        .model_output (model_output),
        .out_vld      (out_vld),
        .pred_class   (pred_class),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, required to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [FRAME_W-1:0] packWord(input frame_t s);
        logic [FRAME_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            w = w | (FRAME_W'(s[i]) << (i * SCORE_W));
        end
        return w;
    endfunction

    function automatic logic [IDX_W-1:0] refArgmax(input frame_t s);
        int best;
        int bestVal;
        best = 0;
        bestVal = int'($signed(s[0]));
        for (int i = 1; i < NUM_CLASS; i++) begin
            if (int'($signed(s[i])) > bestVal) begin
                bestVal = int'($signed(s[i]));
                best = i;
            end
        end
        return IDX_W'(best);
    endfunction

    function automatic logic [SCORE_W-1:0] edgeScore(input int sel);
        case (sel)
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [FRAME_W-1:0] act,
                               input logic [FRAME_W-1:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard when the DUT presents a result or an
    // error pulse; otherwise the word must be zero and the class held.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   at;
        if (!rst) begin
            if (out_vld) begin
                if (expQ.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected_out_vld: out_vld=%0b, required 0 (t=%0t)", out_vld, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("model_output", model_output, e.word);
                    checkOutput("pred_class", FRAME_W'(pred_class), FRAME_W'(e.cls));
                    checkOutput("emit_cycle", FRAME_W'(cyc), FRAME_W'(e.at));
                    heldCls = e.cls;
                end
            end else begin
                checkOutput("quiet_model_output", model_output, '0);
            end
            if (frame_err) begin
                if (errQ.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected_frame_err: frame_err=%0b, required 0 (t=%0t)", frame_err, $time);
                end else begin
                    at = errQ.pop_front();
                    checkOutput("frame_err_cycle", FRAME_W'(cyc), FRAME_W'(at));
                end
            end
            if (score_rdy) begin
                checkOutput("pred_class_hold", FRAME_W'(pred_class), FRAME_W'(heldCls));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge: presents a beat, waits (bounded)
    // for score_rdy and reports the rising edge that will accept it.
    task automatic applyStimulus(input logic [SCORE_W-1:0] data, input logic last,
                                 output int waited, output int acceptCyc);
        score_vld  = 1'b1;
        score_data = data;
        score_last = last;
        waited     = 0;
        while (!score_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!score_rdy) begin
            checksTotal++;
            $display("[TB] FAIL beat_accept_timeout: score_rdy=%0b after %0d cycles, required 1", score_rdy, waited);
        end
        acceptCyc = cyc + 1;
    endtask

    // lastAt: beat carrying score_last; outside 0..NUM_CLASS-1 means none.
    task automatic sendFrame(input frame_t s, input int lastAt, input bit keepValid,
                             output int firstWait);
        int   w;
        int   t;
        int   nBeats;
        exp_t e;
        nBeats = (lastAt >= 0 && lastAt < NUM_CLASS - 1) ? lastAt + 1 : NUM_CLASS;
        firstWait = 0;
        for (int k = 0; k < nBeats; k++) begin
            applyStimulus(s[k], k == lastAt, w, t);
            if (k == 0) firstWait = w;
            if (k == nBeats - 1) begin
                if (nBeats < NUM_CLASS || lastAt != NUM_CLASS - 1) errQ.push_back(t);
                if (nBeats == NUM_CLASS) begin
                    e.word = packWord(s);
                    e.cls  = refArgmax(s);
                    e.at   = t + NUM_CLASS;
                    expQ.push_back(e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!keepValid) begin
            score_vld  = 1'b0;
            score_last = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        score_vld  = 1'b0;
        score_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin : stimulus
        frame_t f;
        int     w;
        int     r;
        int     lastAt;
        bit     keep;

        #1;
        checkOutput("reset_score_rdy", FRAME_W'(score_rdy), '0);
        checkOutput("reset_model_output", model_output, '0);
        checkOutput("reset_out_vld", FRAME_W'(out_vld), '0);
        checkOutput("reset_pred_class", FRAME_W'(pred_class), '0);
        checkOutput("reset_frame_err", FRAME_W'(frame_err), '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rdy_after_release", FRAME_W'(score_rdy), FRAME_W'(1));
        @(negedge clk);

        // Ascending scores: class 9 wins.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(i + 1);
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(2);

        // All equal: tie keeps class 0.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = 8'h05;
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(1);

        // Signed compare: 0x00 beats every negative score.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = 8'hFF;
        f[3] = 8'h80;
        f[7] = 8'h00;
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(13);

        // Reset during ARGMAX: outputs clear at once, frame is lost.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(3 * i + 1);
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expQ.delete();
        heldCls = '0;
        checkOutput("midreset_score_rdy", FRAME_W'(score_rdy), '0);
        checkOutput("midreset_out_vld", FRAME_W'(out_vld), '0);
        checkOutput("midreset_model_output", model_output, '0);
        checkOutput("midreset_pred_class", FRAME_W'(pred_class), '0);
        checkOutput("midreset_frame_err", FRAME_W'(frame_err), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rdy_after_midreset", FRAME_W'(score_rdy), FRAME_W'(1));
        @(negedge clk);
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(20 - i);
        f[5] = 8'h40;
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(14);

        // Early last on beat 4, then a clean descending frame.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(i + 1);
        sendFrame(f, 4, 1'b0, w);
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(NUM_CLASS - i);
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(2);

        // score_vld held high across three frames.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(i + 1);
        sendFrame(f, NUM_CLASS - 1, 1'b1, w);
        for (int i = 0; i < NUM_CLASS; i++) f[i] = 8'hFF;
        f[3] = 8'h80;
        f[7] = 8'h00;
        sendFrame(f, NUM_CLASS - 1, 1'b1, w);
        checkOutput("rdy_low_cycles_1", FRAME_W'(w), FRAME_W'(NUM_CLASS + 1));
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'(i * 7);
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        checkOutput("rdy_low_cycles_2", FRAME_W'(w), FRAME_W'(NUM_CLASS + 1));
        idleCycles(1);

        // Missing last on the final beat: error pulse, frame still emitted.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = SCORE_W'($urandom);
        sendFrame(f, -1, 1'b0, w);
        idleCycles(1);

        // All-zero frame: out_vld with a zero word.
        for (int i = 0; i < NUM_CLASS; i++) f[i] = 8'h00;
        sendFrame(f, NUM_CLASS - 1, 1'b0, w);
        idleCycles(1);

        // Random frames with ties, early/missing last and back-to-back runs.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                f[i] = ($urandom_range(0, 1) == 1) ? SCORE_W'($urandom)
                                                   : edgeScore(int'($urandom_range(0, 3)));
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)      lastAt = int'($urandom_range(0, NUM_CLASS - 2));
            else if (r == 1) lastAt = -1;
            else             lastAt = NUM_CLASS - 1;
            keep = ($urandom_range(0, 3) == 0);
            sendFrame(f, lastAt, keep, w);
            if (!keep) idleCycles(int'($urandom_range(0, 3)));
        end
        idleCycles(1);

        for (int i = 0; i < 60 && (expQ.size() != 0 || errQ.size() != 0); i++) begin
            @(negedge clk);
        end
        checkOutput("pending_frames", FRAME_W'(expQ.size()), '0);
        checkOutput("pending_frame_errs", FRAME_W'(errQ.size()), '0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
